// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: GF(2^8) constant multipliers built from xtime,
// the round back-end FSM states, and state geometry.
package aes_pkg;

  localparam int NB_BYTES = 16;
  localparam int NB_COLS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mixcol_word.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the low byte.
module inv_mixcol_word (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  import aes_pkg::*;

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[7:0];
  assign a1 = col_i[15:8];
  assign a2 = col_i[23:16];
  assign a3 = col_i[31:24];

  // Circulant rows of {0e,0b,0d,09}.
  assign col_o[7:0]   = gmul_0e(a0) ^ gmul_0b(a1) ^ gmul_0d(a2) ^ gmul_09(a3);
  assign col_o[15:8]  = gmul_09(a0) ^ gmul_0e(a1) ^ gmul_0b(a2) ^ gmul_0d(a3);
  assign col_o[23:16] = gmul_0d(a0) ^ gmul_09(a1) ^ gmul_0e(a2) ^ gmul_0b(a3);
  assign col_o[31:24] = gmul_0b(a0) ^ gmul_0d(a1) ^ gmul_09(a2) ^ gmul_0e(a3);

endmodule

// File: rtl/inv_ark_mixcol_stage.sv
// AES-128 decryption round back-end: AddRoundKey at capture, then InvMixColumns
// one column per cycle through a single shared column unit (skipped on the last round).
module inv_ark_mixcol_stage #(
  parameter int NB_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NB_BYTES-1:0] in_state,
  input  logic [8*NB_BYTES-1:0] in_rkey,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NB_BYTES-1:0] out_state
);
  import aes_pkg::*;

  localparam int SW = 8 * NB_BYTES;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic          last_q, last_d;
  logic [SW-1:0] buf_q, buf_d;
  logic [31:0]   col_in, col_out;

  assign col_in = buf_q[32*col_q +: 32];

  inv_mixcol_word u_mix (
    .col_i (col_in),
    .col_o (col_out)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    last_d    = last_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_state ^ in_rkey;
          last_d  = in_last;
          col_d   = 2'd0;
          state_d = in_last ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        buf_d[32*col_q +: 32] = col_out;
        col_d = col_q + 2'd1;
        // A latched last-round block never needs mixing, so leave BUSY at once.
        if (col_q == 2'(NB_COLS - 1) || last_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      last_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  assign out_state = buf_q;

endmodule

// File: tb/tb_inv_ark_mixcol_stage.sv
// Scoreboard bench for inv_ark_mixcol_stage: expected blocks queued at drive time,
// popped and compared when out_valid appears.
module tb_inv_ark_mixcol_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_rkey;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] VEC_IN  = {4{32'hbca14d8e}};
  localparam logic [127:0] VEC_OUT = {4{32'h455313db}};

  always #5 clk = ~clk;

  inv_ark_mixcol_stage #(.NB_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_rkey   (in_rkey),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int k);
    case (k)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic last);
    logic [127:0] s, r;
    logic [7:0]   acc;
    s = st ^ key;
    if (last) return s;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef((j - row + 4) % 4), s[8*(4*c+j) +: 8]);
        r[8*(4*c+row) +: 8] = acc;
      end
    return r;
  endfunction

  // Present one block, push its expectation, and wait (bounded) for out_valid.
  // lat counts rising edges from the accept edge (inclusive) to out_valid seen.
  task automatic drive_block(input logic [127:0] st, input logic [127:0] key,
                             input logic last, output int lat);
    @(negedge clk);
    in_state = st; in_rkey = key; in_last = last; in_valid = 1'b1;
    exp_q.push_back(model(st, key, last));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_expect(output logic [127:0] e);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%h", out_state);
      e = 'x;
    end else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_rkey = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
  endtask

  task automatic finish_handshake(input string nm);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_release valid=%b ready=%b exp valid=0 ready=1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_mix_vector();
    int lat; logic [127:0] e;
    drive_block(VEC_IN, 128'h0, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL mix_latency got=%0d exp=5", lat); end
    pop_expect(e);
    total++; if (out_state !== VEC_OUT) begin bad++; $display("FAIL mix_vector got=%h exp=%h", out_state, VEC_OUT); end
    total++; if (out_state !== e) begin bad++; $display("FAIL mix_model got=%h exp=%h", out_state, e); end
    finish_handshake("mix");
  endtask

  task automatic test_identity();
    int lat; logic [127:0] e;
    drive_block({16{8'h01}}, 128'h0, 1'b0, lat);
    pop_expect(e);
    total++; if (out_state !== {16{8'h01}}) begin bad++; $display("FAIL identity got=%h exp=%h", out_state, {16{8'h01}}); end
    finish_handshake("identity");
  endtask

  task automatic test_last_round();
    int lat; logic [127:0] key, e;
    for (int i = 0; i < 16; i++) key[8*i +: 8] = 8'(i);
    drive_block(128'h0, key, 1'b1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL last_latency got=%0d exp=1", lat); end
    pop_expect(e);
    total++; if (out_state !== 128'h0f0e0d0c0b0a09080706050403020100) begin
      bad++; $display("FAIL last_state got=%h exp=0f0e0d0c0b0a09080706050403020100", out_state);
    end
    finish_handshake("last");
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] e, st, key; logic last;
    for (int n = 0; n < 6; n++) begin
      st   = {$urandom, $urandom, $urandom, $urandom};
      key  = {$urandom, $urandom, $urandom, $urandom};
      last = (n % 3 == 2);
      drive_block(st, key, last, lat);
      total++; if (lat !== (last ? 1 : 5)) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", n, lat, last ? 1 : 5); end
      pop_expect(e);
      total++; if (out_state !== e) begin bad++; $display("FAIL b2b_state[%0d] got=%h exp=%h", n, out_state, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [127:0] e, st2, key2;
    out_ready = 1'b0;
    drive_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    pop_expect(e);
    total++; if (out_state !== e) begin bad++; $display("FAIL bp_first got=%h exp=%h", out_state, e); end
    st2 = {$urandom, $urandom, $urandom, $urandom};
    key2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_state = st2; in_rkey = key2; in_last = 1'b1; in_valid = 1'b1;
    exp_q.push_back(model(st2, key2, 1'b1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== e) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%b ready=%b state=%h exp valid=1 ready=0 state=%h",
                        i, out_valid, in_ready, out_state, e);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_idle_gap valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_accept valid=%b exp=1", out_valid); end
    pop_expect(e);
    total++; if (out_state !== e) begin bad++; $display("FAIL bp_second got=%h exp=%h", out_state, e); end
    finish_handshake("bp");
  endtask

  task automatic test_midop_reset();
    int lat; logic [127:0] e;
    @(negedge clk);
    in_state = VEC_IN; in_rkey = 128'h0; in_last = 1'b0; in_valid = 1'b1;
    exp_q.push_back(VEC_OUT);
    @(posedge clk); #1; in_valid = 1'b0;   // BUSY, column 0
    @(posedge clk); #1;                    // column 1
    @(posedge clk); #1;                    // column 2
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      bad++; $display("FAIL midreset_values ready=%b valid=%b state=%h exp ready=1 valid=0 state=0",
                      in_ready, out_valid, out_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_output[%0d] valid=%b exp=0", i, out_valid); end
    end
    drive_block(VEC_IN, 128'h0, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL midreset_next_latency got=%0d exp=5", lat); end
    pop_expect(e);
    total++; if (out_state !== VEC_OUT) begin bad++; $display("FAIL midreset_next got=%h exp=%h", out_state, VEC_OUT); end
    finish_handshake("midreset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mix_vector();
    test_identity();
    test_last_round();
    test_back_to_back();
    test_backpressure();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_ark_mixcol_stage.md
# inv_ark_mixcol_stage

Registered AES-128 decryption round back-end that consumes the 128-bit InvSubBytes output, applies AddRoundKey, then applies InvMixColumns one column per cycle. The final round (`in_last`) bypasses InvMixColumns. Valid/ready handshakes on both sides let it sit between the InvShiftRows/InvSubBytes front-end and the round controller's state register.

## Interface
Parameters:
- `NB_BYTES`, 16: bytes per AES state; fixed for AES-128, not overridable in practice.

Ports:
- `clk`  in  1  single clock; all flops rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream holds a valid state/key pair.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_state`  in  128  InvSubBytes output; byte i at bits [8*i +: 8].
- `in_rkey`  in  128  round key, same byte layout.
- `in_last`  in  1  final round: skip InvMixColumns.
- `out_valid`  out  1  `out_state` holds a completed result.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  128  result, same byte layout.

## Operation
- Byte layout:
  - Column c = bytes 4c..4c+3.
  - Row r = byte index mod 4; row 0 is the lowest byte of the column.
- Accept when `in_valid && in_ready`:
  - Buffer <= `in_state ^ in_rkey` (AddRoundKey done at capture).
  - Latch `in_last`.
  - Column counter <= 0.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to BUSY if `in_last`=0, else DONE.
  - BUSY: each cycle, replace column[counter] of the buffer with InvMixColumns(column). Counter increments 0..3 and wraps to 0. After the column 3 cycle, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- InvMixColumns per column:
  - Matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.
  - All GF products are 8-bit; built from xtime chains; no wider arithmetic.
- Inputs are ignored unless `in_ready`=1. `in_state`, `in_rkey` and `in_last` are sampled only on the accept edge.
- `out_state` is the buffer register. It is stable from `out_valid` rising until the output handshake.
- No input accept in the same cycle as an output handshake. IDLE always intervenes.

## Timing
- Reset values:
  - FSM = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_state` = 0.
  - Column counter = 0.
  - Latched last = 0.
- Latency, measured from the accept edge:
  - Non-last: `out_valid` high 5 cycles later (1 capture + 4 columns).
  - Last: `out_valid` high 1 cycle later.
- Throughput, with `out_ready` tied high:
  - Non-last: one block per 6 cycles.
  - Last: one block per 2 cycles.
- Backpressure: `out_valid` and `out_state` hold indefinitely while `out_ready`=0; `in_ready` stays 0.
- `out_ready` high outside DONE: no effect.
- `rst_n` low in any state (including mid-BUSY): all registers return to reset values immediately. The partially processed block is discarded; no output is produced for it.
- First accept is possible on the first clock edge after `rst_n` deasserts.

## Structure
- Shared package `aes_pkg`:
  - `xtime` function.
  - GF multiply-by-09/0b/0d/0e functions.
  - FSM state enum (IDLE, BUSY, DONE).
  - `NB_BYTES`, `NB_COLS`=4.
- Sub-module `inv_mixcol_word`:
  - Combinational 32-bit column in -> 32-bit column out.
  - One instance, driven by a counter-selected column mux.
  - Reusable by any later unrolled variant.

## Test plan
- Reset: hold `rst_n`=0, then release -> `in_ready`=1, `out_valid`=0, `out_state`=0.
- InvMixColumns vector:
  - Stimulus: every column bytes 0..3 = 8e,4d,a1,bc; `in_rkey`=0; `in_last`=0.
  - Required: every output column = db,13,53,45; `out_valid` exactly 5 cycles after accept.
- Identity and key path:
  - Stimulus: all bytes 01; `in_rkey` all bytes 00; `in_last`=0.
  - Required: all bytes 01 (InvMixColumns of an all-equal column is identity).
- Last round:
  - Stimulus: `in_state`=0; `in_rkey` bytes i = i (00..0f); `in_last`=1.
  - Required: `out_state` byte i = i; `out_valid` 1 cycle after accept.
- Backpressure:
  - Stimulus: `out_ready`=0 for 10 cycles in DONE while `in_valid`=1.
  - Required: `out_state` unchanged and `in_ready`=0 throughout. Second block is accepted only after the handshake plus one IDLE cycle.
- Mid-op reset:
  - Stimulus: assert `rst_n`=0 while BUSY at column 2.
  - Required: outputs take reset values immediately; no `out_valid` for that block. The next block (8e,4d,a1,bc vector) completes correctly.
